// File: rtl/alu_result_receiver_pkg.sv
// Shared types and helpers for the serial ALU result receiver.
// The CRC3 function is shared so that checkers use the same definition as the RTL.
package alu_result_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RX_FRAME = 2'd1,
        DECODE   = 2'd2
    } rx_state_t;

    typedef logic [2:0] out_crc_t;

    localparam logic DATA       = 1'b0;
    localparam logic CTL        = 1'b1;
    localparam int   FRAME_BITS = 11;
    localparam int   DATA_BYTES = 4;

    // x^3+x+1, init 0, MSB first; the message is {C, 1'b0, flags}
    function automatic out_crc_t crc3(input logic [36:0] msg);
        out_crc_t c;
        logic     fb;
        c = '0;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ msg[i];
            c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_result_receiver_frame_rx.sv
// Serial frame receiver: start detect, 11-bit shift, stop check.
// frame_done_o / stop_err_o are asserted while the stop bit is being sampled.
module alu_frame_rx
    import alu_result_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sout_i,
    output logic       type_o,
    output logic [7:0] payload_o,
    output logic       frame_done_o,
    output logic       stop_err_o
);
    logic       busy_q, busy_d;
    logic [3:0] cnt_q, cnt_d;
    logic [8:0] sh_q, sh_d;

    always_comb begin
        busy_d       = busy_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        frame_done_o = 1'b0;
        stop_err_o   = 1'b0;
        if (!busy_q) begin
            if (!sout_i) begin
                busy_d = 1'b1;
                cnt_d  = 4'd1;
            end
        end else if (cnt_q == 4'(FRAME_BITS - 1)) begin
            // Leaves busy so a start bit in the very next cycle is accepted
            frame_done_o = sout_i;
            stop_err_o   = ~sout_i;
            busy_d       = 1'b0;
            cnt_d        = 4'd0;
        end else begin
            sh_d  = {sh_q[7:0], sout_i};
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            sh_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
        end
    end

    assign type_o    = sh_q[8];
    assign payload_o = sh_q[7:0];

endmodule

// File: rtl/alu_result_receiver.sv
// Reassembles a 32-bit ALU result plus flags/CRC (or an error report) from
// a stream of 11-bit serial frames; reports completion on valid / frame_err.
module alu_result_receiver
    import alu_result_receiver_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sout,
    output logic        valid,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic        crc_ok,
    output logic        err,
    output logic [5:0]  err_flags,
    output logic        parity_ok,
    output logic        frame_err
);
    rx_state_t   state_q, state_d;
    logic        rx_type, rx_done, rx_stop_err;
    logic [7:0]  rx_payload;
    out_crc_t    crc_calc;

    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] acc_q, acc_d, result_q, result_d;
    logic [3:0]  flags_q, flags_d;
    logic [5:0]  err_flags_q, err_flags_d;
    logic        valid_q, valid_d, frame_err_q, frame_err_d;
    logic        crc_ok_q, crc_ok_d, err_q, err_d, parity_ok_q, parity_ok_d;

    alu_frame_rx u_frame_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .sout_i       (sout),
        .type_o       (rx_type),
        .payload_o    (rx_payload),
        .frame_done_o (rx_done),
        .stop_err_o   (rx_stop_err)
    );

    assign crc_calc = crc3({acc_q, 1'b0, rx_payload[6:3]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (!sout) state_d = RX_FRAME;
            RX_FRAME: if (rx_done) state_d = DECODE;
                      else if (rx_stop_err) state_d = IDLE;
            DECODE:   state_d = sout ? IDLE : RX_FRAME;
            default:  state_d = IDLE;
        endcase
    end

    // Decode is registered on the stop-bit edge so reports land in DECODE
    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        acc_d       = acc_q;
        result_d    = result_q;
        flags_d     = flags_q;
        crc_ok_d    = crc_ok_q;
        err_d       = err_q;
        err_flags_d = err_flags_q;
        parity_ok_d = parity_ok_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        if (rx_stop_err) begin
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
            acc_d       = '0;
        end else if (rx_done) begin
            byte_cnt_d = '0;
            acc_d      = '0;
            if (rx_type == DATA) begin
                if (byte_cnt_q == 3'(DATA_BYTES)) begin
                    frame_err_d = 1'b1;
                end else begin
                    acc_d      = {acc_q[23:0], rx_payload};
                    byte_cnt_d = byte_cnt_q + 3'd1;
                end
            end else if (!rx_payload[7]) begin
                if (byte_cnt_q == 3'(DATA_BYTES)) begin
                    valid_d     = 1'b1;
                    result_d    = acc_q;
                    flags_d     = rx_payload[6:3];
                    crc_ok_d    = (crc_calc == rx_payload[2:0]);
                    err_d       = 1'b0;
                    err_flags_d = '0;
                    parity_ok_d = 1'b0;
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                if (byte_cnt_q == 3'd0) begin
                    valid_d     = 1'b1;
                    err_d       = 1'b1;
                    crc_ok_d    = 1'b0;
                    err_flags_d = rx_payload[6:1];
                    parity_ok_d = ~^rx_payload;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q  <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            crc_ok_q    <= 1'b0;
            err_q       <= 1'b0;
            err_flags_q <= '0;
            parity_ok_q <= 1'b0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            crc_ok_q    <= crc_ok_d;
            err_q       <= err_d;
            err_flags_q <= err_flags_d;
            parity_ok_q <= parity_ok_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign crc_ok    = crc_ok_q;
    assign err       = err_q;
    assign err_flags = err_flags_q;
    assign parity_ok = parity_ok_q;

endmodule
